// File: rtl/coordinate_rotator_pkg.sv
// Shared constants for the coordinate rotator: angle format, CORDIC gain,
// arctangent table (full turn = 2^32) and the controller state encoding.
// Ports: none (package).
package coordinate_rotator_pkg;

  localparam int ANGLE_W      = 32;
  localparam int ATAN_ENTRIES = 24;

  // +90 degrees in the turn-fraction angle format
  localparam logic [ANGLE_W-1:0] QUARTER_TURN = 32'h4000_0000;

  // 1/K for the CORDIC gain, 0.607253 in Q0.16
  localparam logic [15:0] CORDIC_GAIN_Q16 = 16'h9B75;

  // atan(2^-i) * 2^32 / (2*pi), rounded to nearest
  localparam logic [ANGLE_W-1:0] ATAN_TABLE [ATAN_ENTRIES] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREROT = 2'd1,
    ITER   = 2'd2,
    SCALE  = 2'd3
  } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup for the CORDIC iteration index.
// Latency: none (pure lookup). Backpressure: not applicable.
// Ports: idx (iteration index), atan_val (angle step, 0 beyond the table).
module cordic_atan_rom
  import coordinate_rotator_pkg::*;
(
  input  logic [4:0]         idx,
  output logic [ANGLE_W-1:0] atan_val
);

  always_comb begin
    atan_val = '0;
    if (int'(idx) < ATAN_ENTRIES) atan_val = ATAN_TABLE[idx];
  end

endmodule

// File: rtl/coordinate_rotator.sv
// Rotates one signed (x,y) offset by a turn-fraction angle with iterative CORDIC.
// Latency: done pulses ITERATIONS+2 edges after start acceptance (18 by default).
// Backpressure: one rotation at a time; start is ignored (not queued) while busy.
// Ports: clk, reset (async high), start/angle/x_in/y_in request,
//        x_out/y_out held result, busy (accept..done), done (1-cycle pulse).
module coordinate_rotator
  import coordinate_rotator_pkg::*;
#(
  parameter int COORD_W    = 11,
  parameter int FRAC_BITS  = 8,
  parameter int ITERATIONS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ANGLE_W-1:0] angle,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               busy,
  output logic               done
);

  // two guard bits absorb the CORDIC gain (~1.65) and the diagonal growth
  localparam int DW = COORD_W + FRAC_BITS + 2;
  localparam int PW = DW + 17;
  localparam int IW = 5;

  localparam logic signed [ANGLE_W-1:0] POS_Q = QUARTER_TURN;
  localparam logic signed [ANGLE_W-1:0] NEG_Q = -POS_Q;
  localparam logic signed [16:0]        GAIN  = {1'b0, CORDIC_GAIN_Q16};
  localparam logic signed [PW-1:0]      RND   = PW'(1) <<< (FRAC_BITS + 15);
  localparam logic signed [PW-1:0]      SAT_MAX = PW'((1 << (COORD_W - 1)) - 1);
  localparam logic signed [PW-1:0]      SAT_MIN = PW'(-(1 << (COORD_W - 1)));

  state_t state_q, state_d;
  logic   ld, pre, it, sc, last_iter;

  logic [ANGLE_W-1:0]        ang_c;
  logic [COORD_W-1:0]        xc, yc;
  logic signed [DW-1:0]      x_q, y_q;
  logic signed [ANGLE_W-1:0] z_q;
  logic [IW-1:0]             i_q;

  logic signed [DW-1:0]      xe, ye, x_pre, y_pre, xs, ys, x_nxt, y_nxt;
  logic signed [ANGLE_W-1:0] z_pre, z_nxt;
  logic [ANGLE_W-1:0]        atan_val;
  logic signed [PW-1:0]      xp, yp, xr, yr;

  function automatic logic [COORD_W-1:0] sat(input logic signed [PW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[COORD_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[COORD_W-1:0];
    return v[COORD_W-1:0];
  endfunction

  cordic_atan_rom u_atan (
    .idx      (i_q),
    .atan_val (atan_val)
  );

  // ---------------- controller ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PREROT;
      PREROT:  state_d = ITER;
      ITER:    if (last_iter) state_d = SCALE;
      SCALE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld        = (state_q == IDLE) && start;
    pre       = (state_q == PREROT);
    it        = (state_q == ITER);
    sc        = (state_q == SCALE);
    busy      = (state_q != IDLE);
    last_iter = (i_q == IW'(ITERATIONS - 1));
  end

  // ---------------- datapath ----------------
  // Quadrant fold: bring the residue into [-90,+90] so CORDIC can converge.
  always_comb begin
    xe    = DW'($signed(xc)) <<< FRAC_BITS;
    ye    = DW'($signed(yc)) <<< FRAC_BITS;
    x_pre = xe;
    y_pre = ye;
    z_pre = ang_c;
    if ($signed(ang_c) > POS_Q) begin
      x_pre = -ye;
      y_pre = xe;
      z_pre = ang_c - QUARTER_TURN;
    end else if ($signed(ang_c) < NEG_Q) begin
      x_pre = ye;
      y_pre = -xe;
      z_pre = ang_c + QUARTER_TURN;
    end
  end

  // One micro-rotation; direction follows the sign of the remaining angle.
  always_comb begin
    xs = x_q >>> i_q;
    ys = y_q >>> i_q;
    if (z_q >= 0) begin
      x_nxt = x_q - ys;
      y_nxt = y_q + xs;
      z_nxt = z_q - $signed(atan_val);
    end else begin
      x_nxt = x_q + ys;
      y_nxt = y_q - xs;
      z_nxt = z_q + $signed(atan_val);
    end
  end

  // Gain compensation, round-half-up back to integer pixels.
  always_comb begin
    xp = PW'(x_q) * PW'(GAIN);
    yp = PW'(y_q) * PW'(GAIN);
    xr = (xp + RND) >>> (FRAC_BITS + 16);
    yr = (yp + RND) >>> (FRAC_BITS + 16);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ang_c <= '0;
      xc    <= '0;
      yc    <= '0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      i_q   <= '0;
      x_out <= '0;
      y_out <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ld) begin
        ang_c <= angle;
        xc    <= x_in;
        yc    <= y_in;
      end
      if (pre) begin
        x_q <= x_pre;
        y_q <= y_pre;
        z_q <= z_pre;
        i_q <= '0;
      end
      if (it) begin
        x_q <= x_nxt;
        y_q <= y_nxt;
        z_q <= z_nxt;
        i_q <= i_q + IW'(1);
      end
      if (sc) begin
        x_out <= sat(xr);
        y_out <= sat(yr);
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coordinate_rotator.sv
module tb_coordinate_rotator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] angle = '0;
  logic [10:0] x_in = '0;
  logic [10:0] y_in = '0;
  logic [10:0] x_out, y_out;
  logic        busy, done;

  int errors = 0;
  int checks = 0;
  int dones = 0;
  int expected_dones = 0;
  int exp_x[$];
  int exp_y[$];
  int mon_ex, mon_ey, mon_gx, mon_gy;

  coordinate_rotator dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .angle (angle),
    .x_in  (x_in),
    .y_in  (y_in),
    .x_out (x_out),
    .y_out (y_out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic int rnd_sat(input real r);
    int v;
    if (r >= 0.0) v = $rtoi(r + 0.5);
    else          v = -$rtoi(-r + 0.5);
    if (v > 1023)  v = 1023;
    if (v < -1024) v = -1024;
    return v;
  endfunction

  // Ideal rotation: counter-clockwise by angle/2^32 of a full turn.
  task automatic push_model(input logic [31:0] a, input int x, input int y);
    real th;
    th = $itor($signed(a)) * 6.283185307179586 / 4294967296.0;
    exp_x.push_back(rnd_sat(x * $cos(th) - y * $sin(th)));
    exp_y.push_back(rnd_sat(x * $sin(th) + y * $cos(th)));
    expected_dones++;
  endtask

  // Monitor: every done pops one expectation; tolerance is 1 LSB per axis.
  always @(negedge clk) begin
    if (!reset && done) begin
      dones++;
      if (exp_x.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with nothing pending, expected no done");
      end else begin
        mon_ex = exp_x.pop_front();
        mon_ey = exp_y.pop_front();
        mon_gx = int'($signed(x_out));
        mon_gy = int'($signed(y_out));
        checks++;
        if (mon_gx > mon_ex + 1 || mon_gx < mon_ex - 1) begin
          errors++;
          $display("FAIL x_out: got %0d expected %0d +-1", mon_gx, mon_ex);
        end
        checks++;
        if (mon_gy > mon_ey + 1 || mon_gy < mon_ey - 1) begin
          errors++;
          $display("FAIL y_out: got %0d expected %0d +-1", mon_gy, mon_ey);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input int x, input int y, input bit expect_result);
    angle = a;
    x_in  = 11'(x);
    y_in  = 11'(y);
    start = 1'b1;
    if (expect_result) push_model(a, x, y);
  endtask

  // Drive a one-cycle start; returns #1 after the acceptance edge.
  task automatic fire(input logic [31:0] a, input int x, input int y, input bit expect_result);
    issue(a, x, y, expect_result);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after an acceptance edge. pulse_at>=0 pulses start on that edge count.
  task automatic wait_done(input string name, input int pulse_at);
    int n;
    bit seen;
    bit busy_ok;
    n = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    check({name, "_busy_on"}, int'(busy), 1);
    while (!seen && n < 60) begin
      @(posedge clk);
      n++;
      #1;
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
      if (pulse_at >= 0) start = (n == pulse_at);
    end
    check({name, "_latency"}, seen ? n : -1, 18);
    check({name, "_busy_span"}, int'(busy_ok), 1);
    check({name, "_busy_at_done"}, int'(busy), 0);
    @(posedge clk);
    #1;
    check({name, "_done_width"}, int'(done), 0);
  endtask

  logic [31:0] d_ang [8] = '{32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 32'h0AAA_AAAA,
                             32'hF555_5556, 32'h8000_0000, 32'h6000_0000, 32'h4000_0001};
  int d_x [8] = '{100, 100, 100, 0, 0, 100, 100, 300};
  int d_y [8] = '{0, 0, 0, -200, -200, 50, 0, -400};

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_x_out", int'(x_out), 0);
    check("rst_y_out", int'(y_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);

    // Directed angles including the quadrant boundaries
    for (int i = 0; i < 8; i++) begin
      fire(d_ang[i], d_x[i], d_y[i], 1'b1);
      wait_done($sformatf("dir%0d", i), -1);
    end

    // Reset in the middle of ITER: aborts without done
    fire(32'h1234_5678, 200, 300, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_x_out", int'(x_out), 0);
    check("midrst_y_out", int'(y_out), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    fire(32'h2000_0000, 100, 0, 1'b1);
    wait_done("post_rst", -1);

    // Second start while busy is ignored
    fire(32'hE000_0000, -300, 250, 1'b1);
    wait_done("ignored", 5);
    repeat (25) @(posedge clk);
    #1;

    // start held high through done: next rotation begins on the edge after done
    issue(32'h3000_0000, 500, -100, 1'b1);
    @(posedge clk);
    #1;
    angle = 32'hA000_0000;
    x_in  = 11'(-250);
    y_in  = 11'(600);
    push_model(32'hA000_0000, -250, 600);
    wait_done("held1", -1);
    start = 1'b0;
    wait_done("held2", -1);

    // Randomized rotations
    for (int i = 0; i < 24; i++) begin
      fire($urandom, int'($urandom_range(0, 1400)) - 700, int'($urandom_range(0, 1400)) - 700, 1'b1);
      wait_done($sformatf("rnd%0d", i), -1);
    end

    repeat (5) @(posedge clk);
    #1;
    check("done_count", dones, expected_dones);
    check("queue_empty", exp_x.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
